// File: rtl/if_id_branch_ctrl_pkg.sv
// Shared definitions for the IF/ID register and branch controller:
// opcodes, controller state encoding, bubble word and source-use helpers.
package if_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // J is the only encoding that reads no register at all.
    function automatic logic readsRs(input logic [5:0] op);
        return op != OP_J;
    endfunction

    function automatic logic readsRt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic isCondBranch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/if_id_branch_ctrl_if.sv
// Fetch/decode boundary bundle: fetched word, hazard sidebands from EX/MEM,
// the IF/ID register view and the redirect/stall return path.
interface if_id_branch_ctrl_if #(parameter int XLEN = 32);

    logic [31:0]     IF_Instruction;
    logic [XLEN-1:0] IF_ProgramCounter;
    logic [XLEN-1:0] RsData;
    logic [XLEN-1:0] RtData;
    logic            EX_RegWrite;
    logic            EX_MemRead;
    logic [4:0]      EX_Dest;
    logic            MEM_MemRead;
    logic [4:0]      MEM_Dest;

    logic [31:0]     ID_Instruction;
    logic [XLEN-1:0] ID_ProgramCounter;
    logic            ID_Valid;
    logic [4:0]      ID_Rs;
    logic [4:0]      ID_Rt;
    logic            ID_BubbleToEx;
    logic [XLEN-1:0] BranchAddress;
    logic            BranchSelection;
    logic            IF_StallReq;

    // slave: the IF/ID controller itself
    modport slave (
        input  IF_Instruction, IF_ProgramCounter, RsData, RtData,
               EX_RegWrite, EX_MemRead, EX_Dest, MEM_MemRead, MEM_Dest,
        output ID_Instruction, ID_ProgramCounter, ID_Valid, ID_Rs, ID_Rt,
               ID_BubbleToEx, BranchAddress, BranchSelection, IF_StallReq
    );

    // master: fetch stage plus the pipeline around it
    modport master (
        output IF_Instruction, IF_ProgramCounter, RsData, RtData,
               EX_RegWrite, EX_MemRead, EX_Dest, MEM_MemRead, MEM_Dest,
        input  ID_Instruction, ID_ProgramCounter, ID_Valid, ID_Rs, ID_Rt,
               ID_BubbleToEx, BranchAddress, BranchSelection, IF_StallReq
    );

endinterface

// File: rtl/if_id_branch_ctrl_branch_resolve.sv
// Combinational branch resolver for the instruction sitting in ID:
// register comparison, PC-relative target adder and jump concatenation.
module branch_resolve
    import if_id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rsData,
    input  logic [XLEN-1:0] rtData,
    output logic            condMet,
    output logic [XLEN-1:0] target
);

    logic [5:0]      opcode;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] brOffset;
    logic [XLEN-1:0] brTarget;
    logic [XLEN-1:0] jTarget;

    assign opcode   = instr[31:26];
    assign pc4      = pc + XLEN'(4);
    assign brOffset = {{(XLEN-18){instr[15]}}, instr[15:0], 2'b00};
    assign brTarget = pc4 + brOffset;
    // Jump stays inside the 256 MB region of the sequential PC.
    assign jTarget  = {pc4[XLEN-1:28], instr[25:0], 2'b00};

    always_comb begin
        condMet = 1'b0;
        target  = '0;
        unique case (opcode)
            OP_BEQ: begin
                condMet = (rsData == rtData);
                target  = brTarget;
            end
            OP_BNE: begin
                condMet = (rsData != rtData);
                target  = brTarget;
            end
            OP_J: begin
                condMet = 1'b1;
                target  = jTarget;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/if_id_branch_ctrl.sv
// IF/ID pipeline register with hazard detection and ID-stage branch
// resolution; stalls fetch on data hazards and flushes on taken transfers.
module if_id_branch_ctrl #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_WORD = if_id_pkg::NOP_WORD
) (
    input logic               ClockInput,
    input logic               ResetInputN,
    if_id_branch_ctrl_if.slave bus
);
    import if_id_pkg::*;

    state_t          state, stateNext;
    logic [31:0]     idInstr, idInstrNext;
    logic [XLEN-1:0] idPc, idPcNext;
    logic            idValid, idValidNext;

    logic [5:0]      opcode;
    logic [4:0]      rs, rt;
    logic            exHit, memHit;
    logic            loadUse, branchDep;
    logic            hazard, taken;
    logic            condMet;
    logic [XLEN-1:0] target;

    assign opcode = idInstr[31:26];
    assign rs     = idInstr[25:21];
    assign rt     = idInstr[20:16];

    // Destination matches a source this instruction really reads; $0 never does.
    assign exHit  = (bus.EX_Dest != 5'd0) &&
                    ((readsRs(opcode) && bus.EX_Dest == rs) ||
                     (readsRt(opcode) && bus.EX_Dest == rt));
    assign memHit = (bus.MEM_Dest != 5'd0) &&
                    ((readsRs(opcode) && bus.MEM_Dest == rs) ||
                     (readsRt(opcode) && bus.MEM_Dest == rt));

    assign loadUse   = bus.EX_MemRead && exHit;
    // Branches compare in ID, so they also wait for ALU results and loads in MEM.
    assign branchDep = isCondBranch(opcode) &&
                       ((bus.EX_RegWrite && exHit) || (bus.MEM_MemRead && memHit));

    assign hazard = idValid && (state != FLUSH) && (loadUse || branchDep);
    assign taken  = idValid && (state != FLUSH) && !hazard && condMet;

    branch_resolve #(.XLEN(XLEN)) uResolve (
        .instr   (idInstr),
        .pc      (idPc),
        .rsData  (bus.RsData),
        .rtData  (bus.RtData),
        .condMet (condMet),
        .target  (target)
    );

    always_comb begin
        stateNext   = state;
        idInstrNext = idInstr;
        idPcNext    = idPc;
        idValidNext = idValid;
        unique case (state)
            RUN, STALL: begin
                if (hazard) begin
                    stateNext = STALL;
                end else if (taken) begin
                    // Drop the sequential fetch already in flight.
                    stateNext   = FLUSH;
                    idInstrNext = NOP_WORD;
                    idPcNext    = '0;
                    idValidNext = 1'b0;
                end else begin
                    stateNext   = RUN;
                    idInstrNext = bus.IF_Instruction;
                    idPcNext    = bus.IF_ProgramCounter;
                    idValidNext = 1'b1;
                end
            end
            FLUSH: begin
                stateNext   = RUN;
                idInstrNext = bus.IF_Instruction;
                idPcNext    = bus.IF_ProgramCounter;
                idValidNext = 1'b1;
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge ClockInput or negedge ResetInputN) begin
        if (!ResetInputN) begin
            state   <= RUN;
            idInstr <= NOP_WORD;
            idPc    <= '0;
            idValid <= 1'b0;
        end else begin
            state   <= stateNext;
            idInstr <= idInstrNext;
            idPc    <= idPcNext;
            idValid <= idValidNext;
        end
    end

    assign bus.ID_Instruction    = idInstr;
    assign bus.ID_ProgramCounter = idPc;
    assign bus.ID_Valid          = idValid;
    assign bus.ID_Rs             = rs;
    assign bus.ID_Rt             = rt;
    assign bus.ID_BubbleToEx     = hazard;
    assign bus.IF_StallReq       = hazard;
    assign bus.BranchSelection   = taken;
    assign bus.BranchAddress     = target;

endmodule

// File: tb/tb_if_id_branch_ctrl.sv
// Bench for if_id_branch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_if_id_branch_ctrl;
    import if_id_pkg::*;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    always #5 clk = ~clk;

    if_id_branch_ctrl_if #(.XLEN(32)) bus();

    if_id_branch_ctrl dut (
        .ClockInput  (clk),
        .ResetInputN (rstN),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // What ID must hold, and whether the last edge issued a redirect.
    logic [31:0] mInstr, mPc;
    logic        mValid, mRedirect;
    logic        eHz, eTk;
    logic [31:0] eAddr;
    logic [5:0]  mOp;
    logic [4:0]  mRs, mRt;
    logic        srcRs, srcRt, condBr, exUses, memUses;
    int          mOff;

    always_comb begin
        mOp     = mInstr[31:26];
        mRs     = mInstr[25:21];
        mRt     = mInstr[20:16];
        srcRs   = (mOp != OP_J);
        srcRt   = (mOp == OP_RTYPE || mOp == OP_BEQ || mOp == OP_BNE);
        condBr  = (mOp == OP_BEQ || mOp == OP_BNE);
        exUses  = bus.EX_Dest != 0 && ((srcRs && bus.EX_Dest == mRs) || (srcRt && bus.EX_Dest == mRt));
        memUses = bus.MEM_Dest != 0 && ((srcRs && bus.MEM_Dest == mRs) || (srcRt && bus.MEM_Dest == mRt));
        eHz     = mValid && ((bus.EX_MemRead && exUses) ||
                             (condBr && ((bus.EX_RegWrite && exUses) || (bus.MEM_MemRead && memUses))));
        eTk     = mValid && !eHz &&
                  (mOp == OP_J ||
                   (mOp == OP_BEQ && bus.RsData == bus.RtData) ||
                   (mOp == OP_BNE && bus.RsData != bus.RtData));
        mOff    = int'($signed(mInstr[15:0]));
        eAddr   = 32'd0;
        if (mOp == OP_J)
            eAddr = ((mPc + 32'd4) & 32'hF000_0000) | ({6'd0, mInstr[25:0]} * 32'd4);
        else if (condBr)
            eAddr = mPc + 32'd4 + 32'(mOff * 4);
    end

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mInstr <= NOP_WORD; mPc <= 0; mValid <= 0; mRedirect <= 0;
        end else if (mRedirect || (!eHz && !eTk)) begin
            mInstr <= bus.IF_Instruction; mPc <= bus.IF_ProgramCounter;
            mValid <= 1; mRedirect <= 0;
        end else if (eTk) begin
            mInstr <= NOP_WORD; mPc <= 0; mValid <= 0; mRedirect <= 1;
        end
    end

    always @(negedge clk) begin
        chk("ID_Instruction",    bus.ID_Instruction, mInstr);
        chk("ID_ProgramCounter", bus.ID_ProgramCounter, mPc);
        chk("ID_Valid",          32'(bus.ID_Valid), 32'(mValid));
        chk("ID_Rs",             32'(bus.ID_Rs), 32'(mInstr[25:21]));
        chk("ID_Rt",             32'(bus.ID_Rt), 32'(mInstr[20:16]));
        chk("ID_BubbleToEx",     32'(bus.ID_BubbleToEx), 32'(eHz));
        chk("IF_StallReq",       32'(bus.IF_StallReq), 32'(eHz));
        chk("BranchSelection",   32'(bus.BranchSelection), 32'(eTk));
        chk("BranchAddress",     bus.BranchAddress, eAddr);
        chk("SelStallExclusive", 32'(bus.BranchSelection & bus.IF_StallReq), 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic setIf(input logic [31:0] ins, input logic [31:0] pc);
        bus.IF_Instruction    = ins;
        bus.IF_ProgramCounter = pc;
    endtask

    task automatic clrSide();
        bus.EX_RegWrite = 0; bus.EX_MemRead = 0; bus.EX_Dest = 0;
        bus.MEM_MemRead = 0; bus.MEM_Dest = 0;
        bus.RsData = 0; bus.RtData = 0;
    endtask

    localparam logic [31:0] BEQ_W = 32'h1022_0003;
    localparam logic [31:0] J_W   = 32'h0800_0040;
    localparam logic [31:0] ADD_W = 32'h0041_1820;   // add $3,$2,$1

    logic [5:0] rop;

    initial begin
        setIf(0, 0);
        clrSide();
        #1 rstN = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst ID_Valid", 32'(bus.ID_Valid), 0);
        chk("rst ID_Instruction", bus.ID_Instruction, 32'h0);
        chk("rst ID_ProgramCounter", bus.ID_ProgramCounter, 32'h0);
        chk("rst IF_StallReq", 32'(bus.IF_StallReq), 0);
        chk("rst BranchSelection", 32'(bus.BranchSelection), 0);
        chk("rst BranchAddress", bus.BranchAddress, 32'h0);
        rstN = 1;

        // straight-line fetch
        tick();
        chk("seq0 ID_Valid", 32'(bus.ID_Valid), 1);
        chk("seq0 ID_ProgramCounter", bus.ID_ProgramCounter, 32'h0);
        setIf(32'h2002_0005, 32'h4);
        tick();
        chk("seq1 ID_ProgramCounter", bus.ID_ProgramCounter, 32'h4);
        chk("seq1 ID_Instruction", bus.ID_Instruction, 32'h2002_0005);
        chk("seq1 IF_StallReq", 32'(bus.IF_StallReq), 0);
        chk("seq1 BranchSelection", 32'(bus.BranchSelection), 0);

        // BEQ taken
        setIf(BEQ_W, 32'h10);
        tick();
        bus.RsData = 7; bus.RtData = 7;
        setIf(32'h2003_0001, 32'h14);
        #1;
        chk("beqT BranchSelection", 32'(bus.BranchSelection), 1);
        chk("beqT BranchAddress", bus.BranchAddress, 32'h20);
        chk("beqT IF_StallReq", 32'(bus.IF_StallReq), 0);
        tick();
        chk("beqT flush ID_Valid", 32'(bus.ID_Valid), 0);
        chk("beqT flush ID_Instruction", bus.ID_Instruction, NOP_WORD);
        chk("beqT flush BranchSelection", 32'(bus.BranchSelection), 0);
        setIf(32'h2004_0009, 32'h20);
        tick();
        chk("beqT target ID_Instruction", bus.ID_Instruction, 32'h2004_0009);
        chk("beqT target ID_ProgramCounter", bus.ID_ProgramCounter, 32'h20);
        chk("beqT target ID_Valid", 32'(bus.ID_Valid), 1);

        // BEQ not taken
        setIf(BEQ_W, 32'h10);
        tick();
        bus.RsData = 7; bus.RtData = 8;
        setIf(32'h2005_0001, 32'h14);
        #1;
        chk("beqN BranchSelection", 32'(bus.BranchSelection), 0);
        chk("beqN BranchAddress", bus.BranchAddress, 32'h20);
        tick();
        chk("beqN ID_Instruction", bus.ID_Instruction, 32'h2005_0001);
        chk("beqN ID_ProgramCounter", bus.ID_ProgramCounter, 32'h14);

        // J
        setIf(J_W, 32'h4000_0000);
        tick();
        setIf(32'h2003_0001, 32'h4000_0004);
        #1;
        chk("j BranchAddress", bus.BranchAddress, 32'h4000_0100);
        chk("j BranchSelection", 32'(bus.BranchSelection), 1);
        tick();
        chk("j flush ID_Valid", 32'(bus.ID_Valid), 0);
        setIf(32'h2006_0002, 32'h4000_0100);
        tick();
        chk("j target ID_ProgramCounter", bus.ID_ProgramCounter, 32'h4000_0100);

        // load-use: exactly one stall cycle
        clrSide();
        setIf(ADD_W, 32'h50);
        tick();
        bus.EX_MemRead = 1; bus.EX_Dest = 2;
        setIf(32'h2007_0003, 32'h54);
        #1;
        chk("lu IF_StallReq", 32'(bus.IF_StallReq), 1);
        chk("lu ID_BubbleToEx", 32'(bus.ID_BubbleToEx), 1);
        chk("lu BranchSelection", 32'(bus.BranchSelection), 0);
        tick();
        bus.EX_MemRead = 0; bus.EX_Dest = 0; bus.MEM_MemRead = 1; bus.MEM_Dest = 2;
        #1;
        chk("lu held ID_Instruction", bus.ID_Instruction, ADD_W);
        chk("lu release IF_StallReq", 32'(bus.IF_StallReq), 0);
        tick();
        clrSide();
        chk("lu next ID_Instruction", bus.ID_Instruction, 32'h2007_0003);
        chk("lu next ID_ProgramCounter", bus.ID_ProgramCounter, 32'h54);

        // asynchronous reset in the middle of a stall
        setIf(ADD_W, 32'h60);
        tick();
        bus.EX_MemRead = 1; bus.EX_Dest = 2;
        tick();
        #2 rstN = 0;
        #1;
        chk("rstStall ID_Valid", 32'(bus.ID_Valid), 0);
        chk("rstStall ID_Instruction", bus.ID_Instruction, 32'h0);
        chk("rstStall IF_StallReq", 32'(bus.IF_StallReq), 0);
        clrSide();
        setIf(32'h2008_0004, 32'h64);
        tick();
        rstN = 1;
        tick();
        chk("rstStall after ID_Instruction", bus.ID_Instruction, 32'h2008_0004);
        chk("rstStall after ID_Valid", 32'(bus.ID_Valid), 1);

        // randomized traffic; the model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            case ($urandom_range(0, 5))
                0: rop = OP_RTYPE;
                1: rop = OP_J;
                2: rop = OP_BEQ;
                3: rop = OP_BNE;
                4: rop = OP_LW;
                default: rop = 6'h08;
            endcase
            setIf({rop, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)},
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                              : $urandom);
            bus.RsData      = $urandom_range(0, 2);
            bus.RtData      = $urandom_range(0, 2);
            bus.EX_RegWrite = 1'($urandom_range(0, 1));
            bus.EX_MemRead  = ($urandom_range(0, 3) == 0);
            bus.EX_Dest     = 5'($urandom_range(0, 3));
            bus.MEM_MemRead = ($urandom_range(0, 3) == 0);
            bus.MEM_Dest    = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) begin
                rstN = 0;
                #2 rstN = 1;
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_branch_ctrl.md
Name: if_id_branch_ctrl

Overview:
- Consumer end of the fetch interface.
- Latches the fetched Instruction and ProgramCounter into the IF/ID pipeline register.
- Resolves BEQ/BNE/J in ID and returns BranchAddress, BranchSelection and IF_StallReq to the fetch stage.
- Sits between the fetch stage and the decode/register-file logic. Inserts bubbles for data hazards and flushes on taken control transfers; MIPS-style encoding, no delay slot.

Parameters:
- XLEN, 32, data and address width.
- NOP_WORD, 32'h0000_0000, instruction word written into IF/ID on reset and on flush.

Ports:
- ClockInput  in  1  single system clock, rising edge.
- ResetInputN  in  1  asynchronous, active-low reset.
- IF_Instruction  in  32  instruction from the fetch stage.
- IF_ProgramCounter  in  32  address of IF_Instruction.
- RsData  in  32  register-file read value for ID_Rs.
- RtData  in  32  register-file read value for ID_Rt.
- EX_RegWrite  in  1  instruction in EX writes a register.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_Dest  in  5  destination register of the instruction in EX.
- MEM_MemRead  in  1  instruction in MEM is a load.
- MEM_Dest  in  5  destination register of the instruction in MEM.
- ID_Instruction  out  32  IF/ID register, instruction.
- ID_ProgramCounter  out  32  IF/ID register, PC.
- ID_Valid  out  1  ID holds a real instruction; 0 means bubble.
- ID_Rs  out  5  ID_Instruction[25:21].
- ID_Rt  out  5  ID_Instruction[20:16].
- ID_BubbleToEx  out  1  EX must take a NOP this cycle.
- BranchAddress  out  32  redirect target to the fetch stage.
- BranchSelection  out  1  fetch stage loads BranchAddress at the next edge.
- IF_StallReq  out  1  fetch stage holds its PC and instruction.

Behaviour:
- Reset: ResetInputN low, taken asynchronously.
  - ID_Instruction=NOP_WORD, ID_ProgramCounter=0, ID_Valid=0, state=RUN.
  - All combinational outputs evaluate to 0 during reset.
  - Reset in the middle of a stall or flush abandons that operation; there is no pending redirect after reset.
- Opcodes (ID_Instruction[31:26]): BEQ 6'h04, BNE 6'h05, J 6'h02, LW 6'h23, R-type 6'h00.
- Source use:
  - R-type, BEQ and BNE read rs and rt.
  - LW and other I-types read rs only.
  - J reads nothing.
- Register 0 never causes a hazard.
- Hazard (combinational, only when ID_Valid=1):
  - Load-use: EX_MemRead and EX_Dest matches a used source.
  - Branch dependency: BEQ/BNE, and either (EX_RegWrite and EX_Dest matches rs or rt) or (MEM_MemRead and MEM_Dest matches rs or rt).
- Branch resolution (combinational, ID_Valid=1, no hazard):
  - BEQ is taken when RsData==RtData. BNE is taken when they differ. J is always taken.
  - Branch target = ID_ProgramCounter + 4 + (sign-extended imm16 << 2), modulo 2^32; wrap-around allowed.
  - Jump target = {PC4[31:28], instr[25:0], 2'b00}, where PC4 = ID_ProgramCounter + 4.
  - BranchAddress shows the computed target whenever ID holds BEQ/BNE/J, otherwise 0.
- Outputs in the hazard cycle: IF_StallReq=1, ID_BubbleToEx=1, BranchSelection=0.
  - Hazard has priority over branch resolution; the branch is evaluated again once the hazard clears.
- State machine, evaluated at each clock edge:
  - RUN, no hazard, not taken: IF/ID <= IF inputs, ID_Valid<=1; stay in RUN.
  - RUN, hazard: hold IF/ID; go to STALL.
  - RUN, taken: IF/ID <= NOP_WORD, ID_Valid<=0. This discards the sequential fetch. Go to FLUSH.
  - STALL: same evaluation as RUN; a hazard that is still present keeps the state in STALL with IF/ID held.
  - FLUSH: IF/ID <= IF inputs (now the target instruction), ID_Valid<=1; go to RUN. Outputs in FLUSH: IF_StallReq=0, BranchSelection=0.
- Latency:
  - IF to ID: 1 cycle.
  - Taken branch penalty: 1 bubble.
  - Load-use penalty: 1 bubble. Branch dependent on a load: 2 bubbles.
- Simultaneous stall and taken branch cannot occur; hazard gating makes them mutually exclusive.
- BranchSelection and IF_StallReq are never both high.

Decomposition:
- Shared package if_id_pkg holds:
  - opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_LW);
  - the state encoding {RUN, STALL, FLUSH};
  - NOP_WORD.
- One sub-module: branch_resolve. It is purely combinational: comparator, target adder and jump concatenation, taking instruction, PC and the two read values.
- Hazard detection and the FSM stay in the top module.

Test Plan:
- Reset, then release; IF_Instruction=32'h0000_0000 and 32'h2002_0005 with PC 0 and 4 → ID_Valid=1, ID_ProgramCounter follows 0 then 4, no stall, no branch.
- BEQ 32'h1022_0003 at PC 0x10, RsData=RtData=7 → BranchSelection=1, BranchAddress=0x20, next cycle ID_Valid=0, then target instruction latched.
- Same BEQ with RsData=7, RtData=8 → not taken, BranchSelection=0, next IF instruction latched normally.
- J 32'h0800_0040 at PC 0x4000_0000 → BranchAddress=0x4000_0100, BranchSelection=1.
- EX_MemRead=1, EX_Dest=2, ID holds add $3,$2,$1 → IF_StallReq=1 and ID_BubbleToEx=1 for exactly 1 cycle, ID_Instruction held, then proceeds.
- ResetInputN driven low mid-STALL, between clock edges → ID_Valid=0 and ID_Instruction=0 immediately; IF_StallReq=0.
